// File: rtl/clk_gen_pulse_pkg.sv
// rtl/clk_gen_pulse_pkg.sv - shared constants for the clock-strobe generator
package clk_gen_pulse_pkg;
   localparam int   MIN_DIV           = 2;
   localparam logic EDGE_RISE         = 1'b0;
   localparam logic EDGE_FALL         = 1'b1;
   localparam int   DIV_W_DEFAULT     = 16;
   localparam int   DIV_RESET_DEFAULT = 4;
endpackage

// File: rtl/clk_gen_load.sv
// rtl/clk_gen_load.sv - divisor shadow register, clamp and div_busy handshake
module clk_gen_load
   import clk_gen_pulse_pkg::*;
#(
   parameter int DIV_W     = DIV_W_DEFAULT,
   parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_busy,
   output logic             apply,
   output logic [DIV_W-1:0] new_div
);

   logic             pending;
   logic             accept;
   logic [DIV_W-1:0] div_clamped;

   // An idle generator has no period to finish, so a pending value applies at once.
   always_comb begin
      accept      = div_load & ~div_busy;
      apply       = pending & (restart | ~en);
      div_clamped = (div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         new_div  <= DIV_W'(DIV_RESET);
         pending  <= 1'b0;
         div_busy <= 1'b0;
      end else if (accept) begin
         new_div  <= div_clamped;
         pending  <= 1'b1;
         div_busy <= en;
      end else if (apply) begin
         pending  <= 1'b0;
         div_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_gen_pulse.sv
// rtl/clk_gen_pulse.sv - divided clock and edge strobe on the fast clock
// CLK_GEN_SYNC_EN adds the sync_in phase-restart input.
module clk_gen_pulse
   import clk_gen_pulse_pkg::*;
#(
   parameter int DIV_W     = DIV_W_DEFAULT,
   parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             EDGE,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
`ifdef CLK_GEN_SYNC_EN
   input  logic             sync_in,
`endif
   output logic             div_busy,
   output logic             clk_out,
   output logic             clk_pulse
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] n_div;
   logic [DIV_W-1:0] new_div;
   logic [DIV_W-1:0] half;
   logic [DIV_W-1:0] cnt_next;
   logic             apply;
   logic             wrap;
   logic             restart;
   logic             out_next;
   logic             pulse_next;

   clk_gen_load #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
   ) u_load (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .restart  (restart),
      .div_in   (div_in),
      .div_load (div_load),
      .div_busy (div_busy),
      .apply    (apply),
      .new_div  (new_div)
   );

   // Edges are detected on the next-state value so the strobe lines up with clk_out.
   always_comb begin
      half = n_div >> 1;
      wrap = en && (cnt == n_div - DIV_W'(1));
`ifdef CLK_GEN_SYNC_EN
      restart = wrap | (en & sync_in);
`else
      restart = wrap;
`endif
      cnt_next   = restart ? '0 : cnt + DIV_W'(1);
      out_next   = (cnt_next >= half);
      pulse_next = (EDGE == EDGE_RISE) ? (~clk_out & out_next) : (clk_out & ~out_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         n_div     <= DIV_W'(DIV_RESET);
         clk_out   <= 1'b0;
         clk_pulse <= 1'b0;
      end else begin
         if (!en) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            clk_pulse <= 1'b0;
         end else begin
            cnt       <= cnt_next;
            clk_out   <= out_next;
            clk_pulse <= pulse_next;
         end
         if (apply) begin
            n_div <= new_div;
         end
      end
   end

endmodule

// File: tb/tb_clk_gen_pulse.sv
// tb/tb_clk_gen_pulse.sv - directed self-checking bench for clk_gen_pulse
module tb_clk_gen_pulse;

   logic        clk;
   logic        rst;
   logic        en;
   logic        EDGE;
   logic [15:0] div_in;
   logic        div_load;
`ifdef CLK_GEN_SYNC_EN
   logic        sync_in;
`endif
   logic        div_busy;
   logic        clk_out;
   logic        clk_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   clk_gen_pulse #(
      .DIV_W     (16),
      .DIV_RESET (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .EDGE      (EDGE),
      .div_in    (div_in),
      .div_load  (div_load),
`ifdef CLK_GEN_SYNC_EN
      .sync_in   (sync_in),
`endif
      .div_busy  (div_busy),
      .clk_out   (clk_out),
      .clk_pulse (clk_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Loads a divisor with the generator idle; it is in effect after the second tick.
   task automatic idle_load(input logic [15:0] d);
      en       = 1'b0;
      tick();
      div_in   = d;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] exp_out4;
      logic [7:0] exp_pls4;
      exp_out4 = 8'b0110_0110;
      exp_pls4 = 8'b0010_0010;

      rst      = 1'b1;
      en       = 1'b0;
      EDGE     = 1'b0;
      div_in   = '0;
      div_load = 1'b0;
`ifdef CLK_GEN_SYNC_EN
      sync_in  = 1'b0;
`endif
      tick();
      tick();
      chk("reset_clk_out", clk_out, 0);
      chk("reset_pulse", clk_pulse, 0);
      chk("reset_busy", div_busy, 0);

      // Default divisor 4, rising-edge strobe
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("def_out_e%0d", i + 1), clk_out, exp_out4[i]);
         chk($sformatf("def_pls_e%0d", i + 1), clk_pulse, exp_pls4[i]);
      end

      // Odd divisor 5, falling-edge strobe
      en       = 1'b0;
      tick();
      div_in   = 16'd5;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      chk("odd_idle_busy0", div_busy, 0);
      tick();
      chk("odd_idle_busy1", div_busy, 0);
      EDGE = 1'b1;
      en   = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk($sformatf("odd_out_e%0d", i), clk_out, ((i % 5) >= 2) ? 1 : 0);
         chk($sformatf("odd_pls_e%0d", i), clk_pulse, ((i % 5) == 0) ? 1 : 0);
      end

      // Mid-run load of 10 at cnt = 1, with a second load while busy
      idle_load(16'd4);
      EDGE = 1'b0;
      en   = 1'b1;
      tick();
      div_in   = 16'd10;
      div_load = 1'b1;
      tick();
      chk("mid_busy_c2", div_busy, 1);
      div_in   = 16'd3;
      tick();
      chk("mid_busy_c3", div_busy, 1);
      div_load = 1'b0;
      tick();
      chk("mid_busy_wrap", div_busy, 0);
      chk("mid_out_wrap", clk_out, 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk($sformatf("mid_out_e%0d", i), clk_out, ((i % 10) >= 5) ? 1 : 0);
         chk($sformatf("mid_pls_e%0d", i), clk_pulse, (i == 5) ? 1 : 0);
      end

      // Clamp: 0 and 1 both behave as divisor 2
      for (int k = 0; k < 2; k++) begin
         idle_load(16'(k));
         EDGE = 1'b1;
         en   = 1'b1;
         for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("clamp%0d_out_e%0d", k, i), clk_out, i % 2);
            chk($sformatf("clamp%0d_pls_e%0d", k, i), clk_pulse, ((i % 2) == 0) ? 1 : 0);
         end
      end

      // Abort by en while clk_out is high
      idle_load(16'd8);
      EDGE = 1'b1;
      en   = 1'b1;
      repeat (5) tick();
      chk("abort_en_high", clk_out, 1);
      en = 1'b0;
      tick();
      chk("abort_en_out", clk_out, 0);
      chk("abort_en_pls", clk_pulse, 0);

      // Abort by reset with a load pending
      en = 1'b1;
      repeat (5) tick();
      chk("abort_rst_high", clk_out, 1);
      div_in   = 16'd6;
      div_load = 1'b1;
      tick();
      chk("abort_rst_busy_set", div_busy, 1);
      div_load = 1'b0;
      rst      = 1'b1;
      tick();
      chk("abort_rst_out", clk_out, 0);
      chk("abort_rst_pls", clk_pulse, 0);
      chk("abort_rst_busy", div_busy, 0);
      rst  = 1'b0;
      EDGE = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("post_rst_out_e%0d", i + 1), clk_out, exp_out4[i]);
         chk($sformatf("post_rst_pls_e%0d", i + 1), clk_pulse, exp_pls4[i]);
      end

`ifdef CLK_GEN_SYNC_EN
      // Sync restart at cnt = 5 with divisor 8
      idle_load(16'd8);
      EDGE = 1'b1;
      en   = 1'b1;
      repeat (5) tick();
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      chk("sync_out", clk_out, 0);
      chk("sync_pls", clk_pulse, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("sync_rise_e%0d", i), clk_out, (i == 4) ? 1 : 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
